// File: rtl/cpu_defs.sv
// Shared LoongArch pipeline definitions: exception codes, CSR numbers,
// WB FSM states and the MEM->WB bundle.
package cpu_defs;

    localparam logic [5:0] ECODE_ADE     = 6'h8;
    localparam logic [5:0] ECODE_ALE     = 6'h9;
    localparam logic [5:0] ECODE_SYS     = 6'hB;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h0;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000c;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;

    typedef enum logic {
        IDLE,
        FLUSH
    } wb_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
        logic        ertn;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        rf_we;
        logic [4:0]  rf_dest;
        logic [31:0] result;
    } ms_ws_t;

endpackage

// File: rtl/wb_commit.sv
// Writeback/commit stage: registers the MEM output, drives CSR access and
// exception/ertn commit, and issues a one-cycle epoch-tagged pipeline flush.
module wb_commit
    import cpu_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ms_to_ws_valid,
    input  logic             ms_epoch,
    input  logic [31:0]      ms_pc,
    input  logic             ms_ex,
    input  logic [5:0]       ms_ecode,
    input  logic [8:0]       ms_esubcode,
    input  logic [31:0]      ms_vaddr,
    input  logic             ms_ertn,
    input  logic             ms_csr_re,
    input  logic             ms_csr_we,
    input  logic [13:0]      ms_csr_num,
    input  logic [31:0]      ms_csr_wmask,
    input  logic [31:0]      ms_csr_wvalue,
    input  logic             ms_rf_we,
    input  logic [4:0]       ms_rf_dest,
    input  logic [31:0]      ms_result,
    output logic             ws_allowin,
    output logic             csr_re,
    output logic             csr_we,
    output logic [13:0]      csr_num,
    output logic [31:0]      csr_wmask,
    output logic [31:0]      csr_wvalue,
    input  logic [31:0]      csr_rvalue,
    output logic             wb_ex,
    output logic             ertn_flush,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_vaddr,
    input  logic [31:0]      ex_entry,
    input  logic [31:0]      ertn_entry,
    output logic             flush,
    output logic [31:0]      flush_target,
    output logic             ws_epoch,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [CNT_W-1:0] retired_cnt
);

    wb_state_t state;
    logic      ws_valid;
    ms_ws_t    ws;
    ms_ws_t    ms_bundle;
    logic      commit;

    assign ms_bundle = '{
        pc:         ms_pc,
        ex:         ms_ex,
        ecode:      ms_ecode,
        esubcode:   ms_esubcode,
        vaddr:      ms_vaddr,
        ertn:       ms_ertn,
        csr_re:     ms_csr_re,
        csr_we:     ms_csr_we,
        csr_num:    ms_csr_num,
        csr_wmask:  ms_csr_wmask,
        csr_wvalue: ms_csr_wvalue,
        rf_we:      ms_rf_we,
        rf_dest:    ms_rf_dest,
        result:     ms_result
    };

    // WB never stalls in IDLE; FLUSH holds the next instruction upstream.
    assign ws_allowin = (state == IDLE);
    assign commit     = ws_valid && (state == IDLE);
    assign flush      = (state == FLUSH);

    always_comb begin
        wb_ex       = 1'b0;
        ertn_flush  = 1'b0;
        wb_ecode    = '0;
        wb_esubcode = '0;
        wb_pc       = '0;
        wb_vaddr    = '0;
        csr_re      = 1'b0;
        csr_we      = 1'b0;
        csr_num     = '0;
        csr_wmask   = '0;
        csr_wvalue  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        if (commit) begin
            wb_ex       = ws.ex;
            ertn_flush  = ws.ertn && !ws.ex;
            wb_ecode    = ws.ecode;
            wb_esubcode = ws.esubcode;
            wb_pc       = ws.pc;
            wb_vaddr    = ws.vaddr;
            csr_re      = ws.csr_re;
            csr_we      = ws.csr_we && !ws.ex;
            csr_num     = ws.csr_num;
            csr_wmask   = ws.csr_wmask;
            csr_wvalue  = ws.csr_wvalue;
            rf_we       = ws.rf_we && !ws.ex && (ws.rf_dest != 5'd0);
            rf_waddr    = ws.rf_dest;
            rf_wdata    = ws.csr_re ? csr_rvalue : ws.result;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid     <= 1'b0;
            ws           <= '0;
            state        <= IDLE;
            ws_epoch     <= 1'b0;
            retired_cnt  <= '0;
            flush_target <= '0;
        end else begin
            if (ws_allowin) begin
                ws_valid <= ms_to_ws_valid && (ms_epoch == ws_epoch);
                ws       <= ms_bundle;
            end
            if (commit) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    // Redirect; the in-flight younger instruction is wrong-path.
                    if (wb_ex || ertn_flush) begin
                        state        <= FLUSH;
                        flush_target <= wb_ex ? ex_entry : ertn_entry;
                        ws_epoch     <= ~ws_epoch;
                        ws_valid     <= 1'b0;
                    end
                end
                FLUSH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
